// File: rtl/tube_scroller.sv
// Tube playfield scroller: shifts tube columns right-to-left across a
// COLS x ROWS grid, spaces tubes apart, detects bird/tube collisions and
// counts the tubes the bird has passed.
module tube_scroller #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int TICK_DIV = 12500000,
   parameter int GAP_COLS = 3,
   parameter int BIRD_COL = 2
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic                    start,
   input  logic [ROWS-1:0]         pattern,
   input  logic                    pat_valid,
   output logic                    pat_req,
   input  logic [$clog2(ROWS)-1:0] bird_row,
   input  logic [$clog2(COLS)-1:0] col_sel,
   output logic [ROWS-1:0]         col_data,
   output logic                    dead,
   output logic [7:0]              score
);

   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SPACE_W = (GAP_COLS > 0) ? $clog2(GAP_COLS + 1) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SPACE_W-1:0] GAP_LOAD  = SPACE_W'(GAP_COLS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   state_t             state_reg;
   logic [TICK_W-1:0]  tick_reg;
   logic [SPACE_W-1:0] space_reg;
   logic [7:0]         score_reg;
   logic               dead_reg;

   // Per-column view of the playfield; column COLS-1 is the entry side.
   logic [ROWS-1:0]    grid [COLS];

   logic               in_run;
   logic               hit;
   logic               step;
   logic               shift;
   logic               begin_game;
   logic [ROWS-1:0]    entry_col;

   assign in_run     = (state_reg == RUN);
   // The bird sits in a fixed column; any tube bit on its row is a crash.
   assign hit        = in_run && grid[BIRD_COL][bird_row];
   assign step       = in_run && (tick_reg == TICK_LAST);
   // A crash on a step cycle freezes the field: no shift, no score.
   assign shift      = step && !hit;
   // start only matters outside RUN; it launches a fresh game.
   assign begin_game = (state_reg != RUN) && start;
   // New column: a tube only when spacing is done and the picker has one.
   assign entry_col  = ((space_reg == '0) && pat_valid) ? pattern : '0;

   assign pat_req  = in_run && (space_reg == '0);
   assign col_data = grid[col_sel];
   assign dead     = dead_reg;
   assign score    = score_reg;

   // One register per column; each takes its right neighbour on a shift.
   for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      logic [ROWS-1:0] col_reg;
      logic [ROWS-1:0] shift_in;

      if (gi == COLS - 1) begin : g_entry
         assign shift_in = entry_col;
      end else begin : g_body
         assign shift_in = grid[gi+1];
      end

      // Column storage: cleared by reset or a new game, loaded on a shift.
      always_ff @(posedge clk) begin
         if (RST || begin_game) begin
            col_reg <= '0;
         end else if (shift) begin
            col_reg <= shift_in;
         end
      end

      assign grid[gi] = col_reg;
   end

   // Game FSM with tick divider, tube spacing counter and score.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_reg <= IDLE;
         tick_reg  <= '0;
         space_reg <= '0;
         score_reg <= '0;
         dead_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DEAD: begin
               if (start) begin
                  state_reg <= RUN;
                  tick_reg  <= '0;
                  space_reg <= '0;
                  score_reg <= '0;
                  dead_reg  <= 1'b0;
               end
            end
            RUN: begin
               if (hit) begin
                  state_reg <= DEAD;
                  dead_reg  <= 1'b1;
               end else if (step) begin
                  tick_reg <= '0;
                  if (space_reg != '0) begin
                     space_reg <= space_reg - SPACE_W'(1);
                  end else if (pat_valid) begin
                     space_reg <= GAP_LOAD;
                  end
                  // The column leaving the bird's position was just passed.
                  if ((grid[BIRD_COL] != '0) && (score_reg != 8'hFF)) begin
                     score_reg <= score_reg + 8'd1;
                  end
               end else begin
                  tick_reg <= tick_reg + TICK_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               dead_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tube_scroller.sv
// Directed bench for tube_scroller (TICK_DIV=4): expectations are queued as
// stimulus is applied and checked in order when the outputs are observed.
module tb_tube_scroller;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [15:0] pattern;
   logic        pat_valid;
   logic        pat_req;
   logic [3:0]  bird_row;
   logic [3:0]  col_sel;
   logic [15:0] col_data;
   logic        dead;
   logic [7:0]  score;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];

   // 100-unit clock period
   always #50 clk = ~clk;

   tube_scroller #(
      .ROWS(16), .COLS(16), .TICK_DIV(4), .GAP_COLS(3), .BIRD_COL(2)
   ) dut (
      .clk(clk),
      .RST(RST),
      .start(start),
      .pattern(pattern),
      .pat_valid(pat_valid),
      .pat_req(pat_req),
      .bird_row(bird_row),
      .col_sel(col_sel),
      .col_data(col_data),
      .dead(dead),
      .score(score)
   );

   // advance n clock edges, leaving time 1 unit after the last edge
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic push_grid_zero(input string tag);
      for (int c = 0; c < 16; c++) push($sformatf("%s_col%0d", tag, c), 16'h0000);
   endtask

   task automatic compare(input logic [15:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty observed=%h required=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
            $display("check %s observed=%h", e.tag, obs);
         else begin
            fails++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic obs_col(input int c);
      col_sel = 4'(c);
      #1;
      compare(col_data);
   endtask

   task automatic obs_grid();
      for (int c = 0; c < 16; c++) obs_col(c);
   endtask

   task automatic obs_dead();
      compare({15'b0, dead});
   endtask

   task automatic obs_score();
      compare({8'b0, score});
   endtask

   task automatic obs_req();
      compare({15'b0, pat_req});
   endtask

   // reset for one cycle, then launch a game; returns in RUN cycle 1 (tick 0)
   task automatic new_game();
      RST = 1'b1;
      cyc(1);
      RST   = 1'b0;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      RST       = 1'b1;
      start     = 1'b0;
      pattern   = 16'h0000;
      pat_valid = 1'b0;
      bird_row  = 4'd0;
      col_sel   = 4'd0;

      // ---- reset state ----
      push("rst_dead", 16'h0);
      push("rst_score", 16'h0);
      push("rst_req", 16'h0);
      push_grid_zero("rst");
      cyc(2);
      obs_dead();
      obs_score();
      obs_req();
      obs_grid();
      RST = 1'b0;
      cyc(1);

      // ---- insertion and spacing ----
      pattern   = 16'h1FFF;
      pat_valid = 1'b1;
      bird_row  = 4'd14;
      start     = 1'b1;
      push("ins_req_run", 16'h1);
      cyc(1);
      start = 1'b0;
      obs_req();
      push("ins_col15_prestep", 16'h0000);
      cyc(3);
      obs_col(15);
      push("ins_step1_col15", 16'h1FFF);
      push("ins_step1_req", 16'h0);
      cyc(1);
      obs_col(15);
      obs_req();
      push("ins_step2_col15", 16'h0000);
      push("ins_step2_col14", 16'h1FFF);
      cyc(4);
      obs_col(15);
      obs_col(14);
      push("ins_step3_req", 16'h0);
      cyc(4);
      obs_req();
      push("ins_step4_req", 16'h1);
      push("ins_step4_col15", 16'h0000);
      cyc(4);
      obs_req();
      obs_col(15);
      push("ins_step5_col15", 16'h1FFF);
      push("ins_step5_col11", 16'h1FFF);
      cyc(4);
      obs_col(15);
      obs_col(11);

      // ---- pass and score ----
      pattern   = 16'h1FFF;
      pat_valid = 1'b1;
      bird_row  = 4'd14;
      new_game();
      cyc(4);
      pat_valid = 1'b0;
      push("pass_step14_col2", 16'h1FFF);
      push("pass_step14_dead", 16'h0);
      push("pass_step14_score", 16'h0);
      cyc(52);
      obs_col(2);
      obs_dead();
      obs_score();
      push("pass_step15_score", 16'h1);
      push("pass_step15_dead", 16'h0);
      push("pass_step15_col1", 16'h1FFF);
      push("pass_step15_col2", 16'h0000);
      cyc(4);
      obs_score();
      obs_dead();
      obs_col(1);
      obs_col(2);

      // ---- collision ----
      pattern   = 16'h1FFF;
      pat_valid = 1'b1;
      bird_row  = 4'd0;
      new_game();
      cyc(4);
      pat_valid = 1'b0;
      push("hit_step14_dead", 16'h0);
      cyc(52);
      obs_dead();
      push("hit_next_dead", 16'h1);
      push("hit_next_score", 16'h0);
      push("hit_next_req", 16'h0);
      cyc(1);
      obs_dead();
      obs_score();
      obs_req();
      push("hit_hold_col2", 16'h1FFF);
      push("hit_hold_col1", 16'h0000);
      push("hit_hold_dead", 16'h1);
      push("hit_hold_score", 16'h0);
      push("hit_hold_req", 16'h0);
      cyc(24);
      obs_col(2);
      obs_col(1);
      obs_dead();
      obs_score();
      obs_req();

      // ---- restart from DEAD ----
      start = 1'b1;
      push("restart_dead", 16'h0);
      push("restart_score", 16'h0);
      push("restart_req", 16'h1);
      push_grid_zero("restart");
      cyc(1);
      start = 1'b0;
      obs_dead();
      obs_score();
      obs_req();
      obs_grid();

      // ---- collision coinciding with a step: crash wins ----
      pattern   = 16'h1FFF;
      pat_valid = 1'b1;
      bird_row  = 4'd14;
      cyc(4);
      pat_valid = 1'b0;
      cyc(52);
      cyc(3);
      bird_row = 4'd0;
      push("coin_dead", 16'h1);
      push("coin_col2", 16'h1FFF);
      push("coin_col1", 16'h0000);
      push("coin_score", 16'h0);
      cyc(1);
      obs_dead();
      obs_col(2);
      obs_col(1);
      obs_score();

      // ---- producer stall ----
      pattern   = 16'hA5A5;
      pat_valid = 1'b0;
      bird_row  = 4'd14;
      new_game();
      pat_valid = 1'b1;
      cyc(3);
      pat_valid = 1'b0;
      push("stall_step1_col15", 16'h0000);
      push("stall_step1_req", 16'h1);
      cyc(1);
      obs_col(15);
      obs_req();
      pat_valid = 1'b1;
      push("stall_step2_col15", 16'hA5A5);
      push("stall_step2_col14", 16'h0000);
      push("stall_step2_req", 16'h0);
      cyc(4);
      obs_col(15);
      obs_col(14);
      obs_req();

      // ---- reset mid-run with score 3, start held high ----
      pattern   = 16'h1FFF;
      pat_valid = 1'b1;
      bird_row  = 4'd14;
      new_game();
      push("mid_score3", 16'h3);
      cyc(92);
      obs_score();
      cyc(2);
      RST   = 1'b1;
      start = 1'b1;
      push("midrst_score", 16'h0);
      push("midrst_dead", 16'h0);
      push("midrst_req", 16'h0);
      push_grid_zero("midrst");
      cyc(1);
      obs_score();
      obs_dead();
      obs_req();
      obs_grid();
      RST = 1'b0;
      push("midrst_start_req", 16'h1);
      cyc(1);
      start = 1'b0;
      obs_req();

      // ---- score saturation (continuous tubes, bird in the gap) ----
      push("sat_score254", 16'd254);
      cyc(4 * 1027);
      obs_score();
      push("sat_score255", 16'd255);
      cyc(16);
      obs_score();
      push("sat_hold255", 16'd255);
      push("sat_dead", 16'h0);
      cyc(64);
      obs_score();
      obs_dead();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/tube_scroller.md
Name: tube_scroller

Overview:
- Consumer end of the tube-pattern interface: takes 16-bit column patterns from the tube picker and scrolls them right-to-left across a COLS x ROWS playfield buffer.
- Inserts blank spacing columns between tubes.
- Detects collisions between the bird and a tube, and counts tubes passed.
- Feeds the LED column driver through a column-select read port, and feeds the game controller through dead/score.

Parameters:
ROWS, 16, rows per column; width of pattern and col_data
COLS, 16, playfield columns; column COLS-1 is the rightmost (entry), column 0 the leftmost (exit)
TICK_DIV, 12500000, clock cycles per scroll step (must be >= 2)
GAP_COLS, 3, blank columns inserted after each tube column
BIRD_COL, 2, fixed playfield column occupied by the bird (0 <= BIRD_COL < COLS)

Ports:
clk  input  1  system clock
RST  input  1  synchronous, active-high reset
start  input  1  begin or restart a game (sampled in IDLE or DEAD)
pattern  input  ROWS  tube column from picker; bit r = row r, 1 = tube, 0 = gap
pat_valid  input  1  pattern is valid this cycle
pat_req  output  1  block wants a tube column at the next step
bird_row  input  $clog2(ROWS)  current bird row
col_sel  input  $clog2(COLS)  column to read for display
col_data  output  ROWS  grid[col_sel], combinational read
dead  output  1  collision occurred; game frozen
score  output  8  tubes passed, saturating at 255

Behaviour:
- Interface facts: one clock (clk); reset RST is synchronous and active-high.
- Reset values: all grid columns 0; score 0; dead 0; state IDLE; tick counter 0; space counter 0; pat_req 0.
- FSM states: IDLE, RUN, DEAD.
  - IDLE: start=1 -> RUN; grid, score, tick and space counters cleared on entry.
  - RUN: collision -> DEAD.
  - DEAD: start=1 -> RUN, with the same clears as from IDLE.
  - start is ignored in RUN.
- Tick counter: counts only in RUN; 0..TICK_DIV-1 then wraps. step=1 on the cycle the counter equals TICK_DIV-1, so the first step occurs on the TICK_DIV-th cycle in RUN.
- Scroll step (registered update at end of the step cycle):
  - grid[i] <= grid[i+1] for i = 0..COLS-2; old grid[0] is discarded.
  - grid[COLS-1] is loaded by the first matching rule:
    - space_cnt==0 and pat_valid=1 -> pattern; space_cnt <= GAP_COLS.
    - space_cnt==0 and pat_valid=0 -> all zeros; space_cnt stays 0 (retry on the next step).
    - space_cnt!=0 -> all zeros; space_cnt <= space_cnt-1.
  - pattern is sampled only on step cycles; pat_valid outside steps has no effect.
- pat_req = (state==RUN) & (space_cnt==0); it is a level signal, not a pulse.
- Scoring: on a step, if old grid[BIRD_COL] != 0 and no collision is detected that cycle, score <= score+1, saturating at 255.
- Collision: evaluated every cycle in RUN as hit = grid[BIRD_COL][bird_row].
  - hit=1 -> next cycle state=DEAD and dead=1.
  - If hit and step coincide, hit wins: no shift, no score, no insertion.
- DEAD: grid, score and counters hold; pat_req=0; col_data still readable.
- dead=1 exactly while in DEAD.
- RST in any state, including mid-step, returns everything to reset values on the next edge and overrides start.
- col_data is purely combinational from grid and col_sel; there is no latency.

Test Plan:
- Reset: assert RST 2 cycles -> dead=0, score=0, pat_req=0, col_data=0 for col_sel 0..15.
- Insertion and spacing (TICK_DIV=4): start, pat_valid=1, pattern=16'h1FFF -> pat_req=1 in RUN; step 1 (4th RUN cycle) gives grid[15]=16'h1FFF and pat_req=0; steps 2-4 insert zeros; pat_req=1 again after step 4; step 5 inserts the second tube.
- Pass and score: bird_row=14, single tube 16'h1FFF -> tube at col 2 after step 14; no hit; score=1 after step 15; dead stays 0.
- Collision: bird_row=0, same stimulus -> dead=1 on the cycle after step 14; score=0; grid[2]=16'h1FFF holds for 20+ further cycles; pat_req=0.
- Producer stall: pat_valid=0 during step 1 -> grid[15]=0 and pat_req stays 1; pat_valid=1 at step 2 -> grid[15]=pattern and grid[14]=0.
- Restart and reset: in DEAD, pulse start -> state RUN, grid and score cleared. Separately, assert RST mid-run with score=3 -> score=0, grid=0, state IDLE next cycle, even with start=1.
